ibis_lighting_sequencer: RTL and testbench
==========================================

Name: ibis_lighting_sequencer

Overview:
Span controller for the 10-phase lighting datapath. It accepts span commands (start x/y, length, light config) and streams per-pixel value pairs into the lighting unit. It drives the unit's enable and register-write strobes, then returns lit values as a backpressured output stream. It sits between the span rasteriser/texel fetch and the framebuffer write path, sustaining one pixel per 10 cycles.

Parameters:
WIDTH, 11, coordinate width; must equal the lighting unit's WIDTH

Ports:
aclk  in  1  clock
aresetn  in  1  reset; also drives the lighting unit's aresetn
cmd_valid  in  1  span command valid
cmd_ready  out  1  span command accepted when both valid and ready are high
cmd_x, cmd_y  in  WIDTH each  span start coordinate
cmd_len  in  WIDTH  pixel count; 0 = empty span
cmd_cfg_write  in  3  lighting register-write mask for the span (bit0 atten, bit1 origin_x, bit2 origin_y)
cmd_attenuation  in  4  attenuation select
cmd_origin_x, cmd_origin_y  in  WIDTH each  light origin
pix_in_valid / pix_in_ready  in / out  1 each  input pixel handshake
pix_in0, pix_in1  in  8 each  lit value and unlit value
pix_out_valid / pix_out_ready  out / in  1 each  output handshake
pix_out_value  out  8  lit result
pix_out_last  out  1  result is the last pixel of its span
lt_enable  out  1  lighting unit enable
lt_write_registers  out  3  lighting unit write mask
lt_x, lt_y, lt_origin_x, lt_origin_y  out  WIDTH each  lighting unit coordinates
lt_attenuation  out  4  lighting unit attenuation
lt_value_in0, lt_value_in1  out  8 each  lighting unit values
lt_value_out  in  8  lighting unit result
lt_ready  in  1  lighting unit is in phase 9 (used only by the assertion check)
busy  out  1  span active, pixel in flight, or output slot full

Behaviour:
- Reset is aresetn, synchronous, active-low; clock is aclk. On reset:
  - cmd_ready=1, pix_in_ready=0, pix_out_valid=0, pix_out_value=0, pix_out_last=0.
  - lt_enable=0, lt_write_registers=0, busy=0.
  - Phase counter p=0, remaining=0, all latched config=0.
  - The unit resets on the same edge, so the phases stay aligned. Reset mid-span drops all in-flight and pending pixels, with no partial output.
- Command latch:
  - cmd_ready = (remaining==0).
  - On handshake, latch x, y, origin_x, origin_y, attenuation, cfg_write; set remaining=cmd_len and first=1.
  - cmd_len==0: the command is consumed and nothing else happens.
- Phase counter p (0..9) mirrors the unit and advances only when lt_enable=1; after 9 it wraps to 0.
  - p==0: pix_in_ready = (remaining!=0). lt_enable = pix_in_valid & pix_in_ready.
  - On that pixel's handshake:
    - lt_x = latched x + count (mod 2^WIDTH); lt_y = latched y.
    - lt_value_in0/1 = pix_in0/1.
    - lt_write_registers = first ? cfg_write : 3'b000.
    - Then clear first, decrement remaining, increment count, and record last=(remaining==1) with the pixel.
  - p in 1..8: lt_enable=1 unconditionally; lt_write_registers=0.
  - p==9: lt_enable = !pix_out_valid | pix_out_ready. The final phase stalls while the output slot is occupied and not popping.
  - Assertion check: lt_ready must equal (p==9) at all times.
- Capture: the cycle after a p==9 enable, load pix_out_value<=lt_value_out and pix_out_last<=recorded last, and set pix_out_valid. The slot is always free on a capture cycle.
- Overlap:
  - The capture cycle may coincide with the next pixel's p==0 handshake.
  - A new command may be accepted while the previous span's last pixel is still in flight.
  - A config write on the new span's first pixel affects only that span.
- Latency and throughput:
  - Input handshake at cycle T gives pix_out_valid at T+11 (unstalled).
  - Peak throughput is 1 pixel per 10 cycles.
- lt_origin_x, lt_origin_y and lt_attenuation are driven continuously from the latched command.
- pix_out_valid clears on pop unless a capture occurs in the same cycle.
- busy = (remaining!=0) | (p!=0) | capture pending | pix_out_valid.

Test Plan:
- Reset, then command x=5, y=7, len=1, cfg=3'b111, atten=0, pix_in0=0x80, pix_in1=0x10 at T -> lt_write_registers=7 at T only; pix_out_valid at T+11 with value 0x80 and last=1.
- len=4, x=2046 (WIDTH=11), inputs always valid -> lt_x sequence 2046, 2047, 0, 1; handshakes at T, T+10, T+20, T+30; lt_write_registers nonzero only at T; last only on the 4th output.
- len=3, pix_out_ready held low for 40 cycles -> pixel 2 stalls at p==9 and lt_enable stays low; no output is lost; releasing ready yields 3 values in order.
- cmd_len=0 -> cmd_ready stays 1, no lt_enable pulses, no output, busy=0.
- Two back-to-back commands, second atten=0xF with cfg=3'b001 -> the second is accepted while the first span's last pixel is at p>0; second-span outputs equal pix_in1.
- aresetn low at p==5 of pixel 2 -> next cycle all outputs at reset values and p=0; a fresh len=1 command completes with 11-cycle latency.

Source files
------------

// File: rtl/ibis_lighting_sequencer_if.sv
// Span command, pixel stream and lighting-unit bus around ibis_lighting_sequencer.
// The master side is the sequencer; the slave side is the rasteriser, framebuffer path and lighting unit.
interface ibis_lighting_sequencer_if #(
   parameter int WIDTH = 11
);
   logic             cmd_valid, cmd_ready;
   logic [WIDTH-1:0] cmd_x, cmd_y, cmd_len, cmd_origin_x, cmd_origin_y;
   logic [2:0]       cmd_cfg_write;
   logic [3:0]       cmd_attenuation;
   logic             pix_in_valid, pix_in_ready;
   logic [7:0]       pix_in0, pix_in1;
   logic             pix_out_valid, pix_out_ready, pix_out_last;
   logic [7:0]       pix_out_value;
   logic             lt_enable, lt_ready;
   logic [2:0]       lt_write_registers;
   logic [WIDTH-1:0] lt_x, lt_y, lt_origin_x, lt_origin_y;
   logic [3:0]       lt_attenuation;
   logic [7:0]       lt_value_in0, lt_value_in1, lt_value_out;
   logic             busy;

   modport master (
      input  cmd_valid, cmd_x, cmd_y, cmd_len, cmd_cfg_write, cmd_attenuation,
             cmd_origin_x, cmd_origin_y, pix_in_valid, pix_in0, pix_in1,
             pix_out_ready, lt_value_out, lt_ready,
      output cmd_ready, pix_in_ready, pix_out_valid, pix_out_value, pix_out_last,
             lt_enable, lt_write_registers, lt_x, lt_y, lt_origin_x, lt_origin_y,
             lt_attenuation, lt_value_in0, lt_value_in1, busy
   );

   modport slave (
      output cmd_valid, cmd_x, cmd_y, cmd_len, cmd_cfg_write, cmd_attenuation,
             cmd_origin_x, cmd_origin_y, pix_in_valid, pix_in0, pix_in1,
             pix_out_ready, lt_value_out, lt_ready,
      input  cmd_ready, pix_in_ready, pix_out_valid, pix_out_value, pix_out_last,
             lt_enable, lt_write_registers, lt_x, lt_y, lt_origin_x, lt_origin_y,
             lt_attenuation, lt_value_in0, lt_value_in1, busy
   );
endinterface

// File: rtl/ibis_lighting_sequencer.sv
// Span sequencer for the 10-phase lighting unit: one pixel per 10 cycles,
// phase counter kept in lockstep with the unit, single-entry backpressured output slot.
module ibis_lighting_sequencer #(
   parameter int WIDTH = 11
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   ibis_lighting_sequencer_if.master bus
);
   localparam logic [3:0]       LAST_PH = 4'd9;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [3:0]       p_q, p_d;
   logic [WIDTH-1:0] rem_q, rem_d, cnt_q, cnt_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d, ox_q, ox_d, oy_q, oy_d;
   logic [3:0]       att_q, att_d;
   logic [2:0]       cfg_q, cfg_d;
   logic             first_q, first_d, last_q, last_d, cap_q, cap_d;
   logic             out_vld_q, out_vld_d, out_last_q, out_last_d;
   logic [7:0]       out_val_q, out_val_d;
   logic             cmd_fire, pix_rdy, pix_fire, lt_en, pop;

   always_comb begin
      cmd_fire = bus.cmd_valid & (rem_q == '0);
      pix_rdy  = (p_q == 4'd0) & (rem_q != '0);
      pix_fire = bus.pix_in_valid & pix_rdy;
      pop      = out_vld_q & bus.pix_out_ready;

      // Phase 9 is the only place a full output slot can hold the unit back.
      if (p_q == 4'd0)         lt_en = pix_fire;
      else if (p_q == LAST_PH) lt_en = !out_vld_q | bus.pix_out_ready;
      else                     lt_en = 1'b1;

      p_d = p_q;
      if (lt_en) p_d = (p_q == LAST_PH) ? 4'd0 : p_q + 4'd1;

      rem_d   = rem_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      att_d   = att_q;
      cfg_d   = cfg_q;
      first_d = first_q;
      last_d  = last_q;
      if (cmd_fire) begin
         x_d     = bus.cmd_x;
         y_d     = bus.cmd_y;
         ox_d    = bus.cmd_origin_x;
         oy_d    = bus.cmd_origin_y;
         att_d   = bus.cmd_attenuation;
         cfg_d   = bus.cmd_cfg_write;
         rem_d   = bus.cmd_len;
         cnt_d   = '0;
         first_d = 1'b1;
      end else if (pix_fire) begin
         first_d = 1'b0;
         rem_d   = rem_q - ONE;
         cnt_d   = cnt_q + ONE;
         last_d  = (rem_q == ONE);
      end

      // The unit's result is stable the cycle after its phase-9 step.
      cap_d      = lt_en & (p_q == LAST_PH);
      out_vld_d  = out_vld_q;
      out_val_d  = out_val_q;
      out_last_d = out_last_q;
      if (cap_q) begin
         out_vld_d  = 1'b1;
         out_val_d  = bus.lt_value_out;
         out_last_d = last_q;
      end else if (pop) begin
         out_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         p_q        <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         att_q      <= '0;
         cfg_q      <= '0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         cap_q      <= 1'b0;
         out_vld_q  <= 1'b0;
         out_val_q  <= '0;
         out_last_q <= 1'b0;
      end else begin
         p_q        <= p_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         att_q      <= att_d;
         cfg_q      <= cfg_d;
         first_q    <= first_d;
         last_q     <= last_d;
         cap_q      <= cap_d;
         out_vld_q  <= out_vld_d;
         out_val_q  <= out_val_d;
         out_last_q <= out_last_d;
      end
   end

   assign bus.cmd_ready          = (rem_q == '0);
   assign bus.pix_in_ready       = pix_rdy;
   assign bus.pix_out_valid      = out_vld_q;
   assign bus.pix_out_value      = out_val_q;
   assign bus.pix_out_last       = out_last_q;
   assign bus.lt_enable          = lt_en;
   assign bus.lt_write_registers = (pix_fire & first_q) ? cfg_q : 3'b000;
   assign bus.lt_x               = x_q + cnt_q;
   assign bus.lt_y               = y_q;
   assign bus.lt_origin_x        = ox_q;
   assign bus.lt_origin_y        = oy_q;
   assign bus.lt_attenuation     = att_q;
   assign bus.lt_value_in0       = bus.pix_in0;
   assign bus.lt_value_in1       = bus.pix_in1;
   assign bus.busy               = (rem_q != '0) | (p_q != 4'd0) | cap_q | out_vld_q;

`ifndef SYNTHESIS
   always_ff @(posedge aclk) begin
      if (aresetn) assert (bus.lt_ready == (p_q == LAST_PH)) else $error("lighting unit phase out of step");
   end
`endif
endmodule

// File: tb/tb_ibis_lighting_sequencer.sv
// Bench for ibis_lighting_sequencer: a behavioural 10-phase lighting unit, a span-level
// reference model feeding an expected-output queue, and a monitor that checks every pop.
module tb_ibis_lighting_sequencer;
   localparam int W = 11;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   ibis_lighting_sequencer_if #(.WIDTH(W)) bus();
   ibis_lighting_sequencer #(.WIDTH(W)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

   int n_vec = 0, n_err = 0, cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Attenuation 0 gives the lit value, 15 the unlit value, in between a linear blend.
   function automatic logic [7:0] light(input logic [3:0] a, input logic [7:0] v0, input logic [7:0] v1);
      int r;
      r = (int'(v0) * (15 - int'(a)) + int'(v1) * int'(a)) / 15;
      return r[7:0];
   endfunction

   // Behavioural lighting unit
   logic [3:0] u_ph, u_att;
   logic [7:0] u_in0, u_in1, u_out;
   always @(posedge aclk) begin
      if (!aresetn) begin
         u_ph <= 0; u_att <= 0; u_in0 <= 0; u_in1 <= 0; u_out <= 0;
      end else if (bus.lt_enable) begin
         if (u_ph == 0) begin
            if (bus.lt_write_registers[0]) u_att <= bus.lt_attenuation;
            u_in0 <= bus.lt_value_in0;
            u_in1 <= bus.lt_value_in1;
         end
         if (u_ph == 9) begin
            u_out <= light(u_att, u_in0, u_in1);
            u_ph  <= 0;
         end else u_ph <= u_ph + 4'd1;
      end
   end
   assign bus.lt_value_out = u_out;
   assign bus.lt_ready     = (u_ph == 9);

   typedef struct { logic [7:0] val; logic last; int t; } exp_t;
   exp_t sbq[$];
   logic lat_chk = 1'b1;
   logic per_chk = 1'b0;
   int   rdy_mode = 0;

   always @(posedge aclk) begin
      #1;
      case (rdy_mode)
         0:       bus.pix_out_ready = 1'b1;
         1:       bus.pix_out_ready = ($urandom_range(0, 3) != 0);
         default: bus.pix_out_ready = 1'b0;
      endcase
   end

   // Monitor: scoreboard pops and per-phase enable rules
   always @(negedge aclk) begin
      if (aresetn) begin
         if (bus.pix_out_valid && bus.pix_out_ready) begin
            if (sbq.size() == 0) chk("unexpected_output", 32'(bus.pix_out_value), 32'hFFFF);
            else begin
               exp_t e;
               e = sbq.pop_front();
               chk("out_value", 32'(bus.pix_out_value), 32'(e.val));
               chk("out_last", 32'(bus.pix_out_last), 32'(e.last));
               if (lat_chk) chk("latency", 32'(cyc - e.t), 32'd11);
            end
         end
         if (u_ph == 0 && !(bus.pix_in_valid && bus.pix_in_ready)) begin
            chk("idle_enable", 32'(bus.lt_enable), 0);
            chk("idle_wr", 32'(bus.lt_write_registers), 0);
         end else if (u_ph != 0 && u_ph != 9) begin
            chk("mid_enable", 32'(bus.lt_enable), 1);
            chk("mid_wr", 32'(bus.lt_write_registers), 0);
         end else if (u_ph == 9) begin
            chk("p9_enable", 32'(bus.lt_enable), 32'(!bus.pix_out_valid || bus.pix_out_ready));
         end
      end
   end

   // Span-level reference state
   int cur_x, cur_y, cur_len, cur_cfg, cur_att, cur_ox, cur_oy, pix_i, prev_hs, acc_ph;
   int model_att = 0;

   task automatic send_cmd(input int x, input int y, input int len, input int cfg,
                           input int att, input int ox, input int oy);
      int k;
      bus.cmd_valid = 1'b1;
      bus.cmd_x = x[W-1:0]; bus.cmd_y = y[W-1:0]; bus.cmd_len = len[W-1:0];
      bus.cmd_cfg_write = cfg[2:0]; bus.cmd_attenuation = att[3:0];
      bus.cmd_origin_x = ox[W-1:0]; bus.cmd_origin_y = oy[W-1:0];
      for (k = 0; k < 300; k++) begin
         @(negedge aclk);
         if (bus.cmd_ready) break;
      end
      if (k == 300) chk("cmd_timeout", 0, 1);
      acc_ph = int'(u_ph);
      cur_x = x; cur_y = y; cur_len = len; cur_cfg = cfg; cur_att = att;
      cur_ox = ox; cur_oy = oy; pix_i = 0;
      @(posedge aclk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic send_pix(input int in0, input int in1);
      int k;
      exp_t e;
      bus.pix_in_valid = 1'b1; bus.pix_in0 = in0[7:0]; bus.pix_in1 = in1[7:0];
      for (k = 0; k < 300; k++) begin
         @(negedge aclk);
         if (bus.pix_in_ready) break;
      end
      if (k == 300) chk("pix_timeout", 0, 1);
      else begin
         chk("hs_enable", 32'(bus.lt_enable), 1);
         chk("lt_x", 32'(bus.lt_x), (cur_x + pix_i) % 2048);
         chk("lt_y", 32'(bus.lt_y), cur_y);
         chk("lt_wr", 32'(bus.lt_write_registers), (pix_i == 0) ? cur_cfg : 0);
         chk("lt_att", 32'(bus.lt_attenuation), cur_att);
         chk("lt_origin", 32'({bus.lt_origin_y, bus.lt_origin_x}), (cur_oy << W) | cur_ox);
         chk("lt_vals", 32'({bus.lt_value_in1, bus.lt_value_in0}), ((in1 & 255) << 8) | (in0 & 255));
         if (per_chk && pix_i > 0) chk("period", 32'(cyc - prev_hs), 10);
         prev_hs = cyc;
         if (pix_i == 0 && cur_cfg[0]) model_att = cur_att;
         e.val  = light(model_att[3:0], in0[7:0], in1[7:0]);
         e.last = (pix_i == cur_len - 1);
         e.t    = cyc;
         sbq.push_back(e);
         pix_i++;
      end
      @(posedge aclk); #1;
      bus.pix_in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge aclk);
         if (sbq.size() == 0 && !bus.busy) break;
      end
      chk("drain", 32'(sbq.size()), 0);
      chk("drain_busy", 32'(bus.busy), 0);
      @(posedge aclk); #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
      chk({tag, "_pix_in_ready"}, 32'(bus.pix_in_ready), 0);
      chk({tag, "_out_valid"}, 32'(bus.pix_out_valid), 0);
      chk({tag, "_out_value"}, 32'(bus.pix_out_value), 0);
      chk({tag, "_out_last"}, 32'(bus.pix_out_last), 0);
      chk({tag, "_lt_enable"}, 32'(bus.lt_enable), 0);
      chk({tag, "_lt_wr"}, 32'(bus.lt_write_registers), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
   endtask

   initial begin
      bus.cmd_valid = 0; bus.cmd_x = 0; bus.cmd_y = 0; bus.cmd_len = 0;
      bus.cmd_cfg_write = 0; bus.cmd_attenuation = 0; bus.cmd_origin_x = 0; bus.cmd_origin_y = 0;
      bus.pix_in_valid = 0; bus.pix_in0 = 0; bus.pix_in1 = 0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk_reset_state("rst");
      @(posedge aclk); #1;
      aresetn = 1'b1;

      // Single pixel, all registers written, attenuation 0 -> lit value
      send_cmd(5, 7, 1, 7, 0, 100, 200);
      send_pix(8'h80, 8'h10);
      drain();

      // Coordinate wrap at the top of the range, back-to-back every 10 cycles
      per_chk = 1'b1;
      send_cmd(2046, 3, 4, 3, 5, 11, 22);
      for (int i = 0; i < 4; i++) send_pix($urandom_range(0, 255), $urandom_range(0, 255));
      per_chk = 1'b0;
      drain();

      // Output held off for 40 cycles: pixel 2 parks at phase 9
      lat_chk = 1'b0;
      send_cmd(50, 60, 3, 0, 0, 1, 2);
      rdy_mode = 2;
      fork
         for (int i = 0; i < 3; i++) send_pix(8'h11 * (i + 1), 8'h22 * (i + 1));
         begin
            repeat (30) @(negedge aclk);
            chk("stall_phase", 32'(u_ph), 9);
            chk("stall_enable", 32'(bus.lt_enable), 0);
            chk("stall_valid", 32'(bus.pix_out_valid), 1);
            repeat (10) @(posedge aclk);
            rdy_mode = 0;
         end
      join
      drain();
      lat_chk = 1'b1;

      // Empty span
      send_cmd(1, 1, 0, 7, 9, 3, 3);
      for (int i = 0; i < 15; i++) begin
         @(negedge aclk);
         chk("len0_cmd_ready", 32'(bus.cmd_ready), 1);
         chk("len0_enable", 32'(bus.lt_enable), 0);
         chk("len0_out_valid", 32'(bus.pix_out_valid), 0);
         chk("len0_busy", 32'(bus.busy), 0);
      end
      @(posedge aclk); #1;

      // Back-to-back spans; second accepted while the first's last pixel is in flight
      send_cmd(10, 20, 2, 1, 0, 5, 5);
      send_pix(8'hA0, 8'h0A);
      send_pix(8'hB0, 8'h0B);
      send_cmd(30, 40, 2, 1, 15, 6, 6);
      chk("accept_in_flight", 32'(acc_ph != 0), 1);
      send_pix(8'hC0, 8'h0C);
      send_pix(8'hD0, 8'h0D);
      drain();

      // Reset at phase 5 of pixel 2 drops everything in flight
      send_cmd(100, 5, 3, 1, 7, 9, 9);
      send_pix(8'h40, 8'h90);
      send_pix(8'h50, 8'hA0);
      repeat (4) @(posedge aclk);
      #1;
      aresetn = 1'b0;
      sbq.delete();
      model_att = 0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk);
      chk_reset_state("midrst");
      chk("midrst_phase", 32'(u_ph), 0);
      @(posedge aclk); #1;
      send_cmd(7, 7, 1, 0, 0, 0, 0);
      send_pix(8'h33, 8'hCC);
      drain();

      // Randomised spans with random output backpressure and input gaps
      lat_chk = 1'b0;
      rdy_mode = 1;
      for (int s = 0; s < 12; s++) begin
         send_cmd($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 5),
                  $urandom_range(0, 7), $urandom_range(0, 15),
                  $urandom_range(0, 2047), $urandom_range(0, 2047));
         for (int i = 0; i < cur_len; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge aclk);
            #1;
            send_pix($urandom_range(0, 255), $urandom_range(0, 255));
         end
      end
      rdy_mode = 0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
